// File: rtl/wb_stage_mlane.sv
// Multi-lane MIPS writeback stage: registered retire bundle, forwarding, instret.
// Optional retirement trace FIFO and debug_wb_* serialisation when WB_TRACE_EN is defined.
module wb_stage_mlane #(
  parameter int LANES       = 2,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int TRACE_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES-1:0]              in_lane_vld,
  input  logic [LANES*32-1:0]           in_pc,
  input  logic [LANES-1:0]              in_rf_we,
  input  logic [LANES*ADDR_W-1:0]       in_rf_waddr,
  input  logic [LANES*DATA_W-1:0]       in_rf_wdata,
  input  logic [1:0]                    in_hilo_we,
  input  logic [DATA_W-1:0]             in_hi,
  input  logic [DATA_W-1:0]             in_lo,
  output logic [LANES-1:0]              rf_we,
  output logic [LANES*ADDR_W-1:0]       rf_waddr,
  output logic [LANES*DATA_W-1:0]       rf_wdata,
  output logic [LANES*(1+ADDR_W+DATA_W)-1:0] fwd_rf_bus,
  output logic [1:0]                    hilo_we,
  output logic [DATA_W-1:0]             hi_o,
  output logic [DATA_W-1:0]             lo_o,
  output logic [2+2*DATA_W-1:0]         fwd_hilo_bus,
  output logic [63:0]                   instret,
  output logic [31:0]                   debug_wb_pc,
  output logic [3:0]                    debug_wb_rf_wen,
  output logic [4:0]                    debug_wb_rf_wnum,
  output logic [31:0]                   debug_wb_rf_wdata,
  output logic                          trace_busy
);

  localparam int LW = 1 + ADDR_W + DATA_W;
  localparam int CW = $clog2(TRACE_DEPTH) + 1;

  logic             acc;
  logic [LANES-1:0] eff;
  logic [LANES-1:0] win;
  logic [CW-1:0]    nvld;

  assign acc = in_valid & in_ready & ~flush;

  always_comb begin
    nvld = '0;
    for (int i = 0; i < LANES; i++) nvld = nvld + CW'(in_lane_vld[i]);
  end

  // Same-address writes within a bundle: the highest lane keeps its enable.
  always_comb begin
    eff = '0;
    win = '0;
    for (int i = 0; i < LANES; i++)
      eff[i] = in_lane_vld[i] & in_rf_we[i] & (in_rf_waddr[i*ADDR_W +: ADDR_W] != '0);
    for (int i = 0; i < LANES; i++) begin
      win[i] = eff[i];
      for (int j = i + 1; j < LANES; j++)
        if (eff[j] && (in_rf_waddr[j*ADDR_W +: ADDR_W] == in_rf_waddr[i*ADDR_W +: ADDR_W]))
          win[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !acc) begin
      rf_we    <= '0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      hilo_we  <= '0;
      hi_o     <= '0;
      lo_o     <= '0;
    end else begin
      rf_we    <= win;
      rf_waddr <= in_rf_waddr;
      rf_wdata <= in_rf_wdata;
      hilo_we  <= in_hilo_we;
      hi_o     <= in_hi;
      lo_o     <= in_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)      instret <= '0;
    else if (acc) instret <= instret + 64'(nvld);
  end

  for (genvar g = 0; g < LANES; g++) begin : g_fwd
    assign fwd_rf_bus[g*LW +: LW] = {rf_we[g], rf_waddr[g*ADDR_W +: ADDR_W],
                                     rf_wdata[g*DATA_W +: DATA_W]};
  end

  assign fwd_hilo_bus = {hilo_we, hi_o, lo_o};

`ifdef WB_TRACE_EN
  localparam int PW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
  localparam int SW = CW + 1;

  logic [31:0]       t_pc    [TRACE_DEPTH];
  logic              t_we    [TRACE_DEPTH];
  logic [ADDR_W-1:0] t_waddr [TRACE_DEPTH];
  logic [DATA_W-1:0] t_wdata [TRACE_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     off [LANES];
  logic              pop;

  function automatic logic [PW-1:0] wrap(input logic [SW-1:0] v);
    return (TRACE_DEPTH == 1) ? '0 : PW'(v);
  endfunction

  // Valid lanes are packed contiguously: each lane's slot is the count of valid lanes below it.
  always_comb begin
    logic [CW-1:0] run;
    run = '0;
    for (int i = 0; i < LANES; i++) begin
      off[i] = run;
      run    = run + CW'(in_lane_vld[i]);
    end
  end

  assign pop        = (count != '0);
  assign trace_busy = pop;
  assign in_ready   = (32'(TRACE_DEPTH) - 32'(count)) >= 32'(LANES);

  always_ff @(posedge clk) begin
    if (acc) begin
      for (int i = 0; i < LANES; i++) begin
        if (in_lane_vld[i]) begin
          t_pc   [wrap(SW'(wr_ptr) + SW'(off[i]))] <= in_pc[i*32 +: 32];
          t_we   [wrap(SW'(wr_ptr) + SW'(off[i]))] <= in_rf_we[i];
          t_waddr[wrap(SW'(wr_ptr) + SW'(off[i]))] <= in_rf_waddr[i*ADDR_W +: ADDR_W];
          t_wdata[wrap(SW'(wr_ptr) + SW'(off[i]))] <= in_rf_wdata[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      debug_wb_pc       <= '0;
      debug_wb_rf_wen   <= '0;
      debug_wb_rf_wnum  <= '0;
      debug_wb_rf_wdata <= '0;
    end else begin
      if (acc) wr_ptr <= wrap(SW'(wr_ptr) + SW'(nvld));
      if (pop) begin
        debug_wb_pc       <= t_pc[rd_ptr];
        debug_wb_rf_wen   <= {4{t_we[rd_ptr]}};
        debug_wb_rf_wnum  <= 5'(t_waddr[rd_ptr]);
        debug_wb_rf_wdata <= 32'(t_wdata[rd_ptr]);
        rd_ptr            <= wrap(SW'(rd_ptr) + SW'(1));
      end else begin
        debug_wb_pc       <= '0;
        debug_wb_rf_wen   <= '0;
        debug_wb_rf_wnum  <= '0;
        debug_wb_rf_wdata <= '0;
      end
      count <= count + (acc ? nvld : '0) - CW'(pop);
    end
  end
`else
  logic unused_trace;
  assign unused_trace      = ^in_pc;
  assign in_ready          = 1'b1;
  assign trace_busy        = 1'b0;
  assign debug_wb_pc       = '0;
  assign debug_wb_rf_wen   = '0;
  assign debug_wb_rf_wnum  = '0;
  assign debug_wb_rf_wdata = '0;
`endif

endmodule

// File: tb/tb_wb_stage_mlane.sv
// Randomised self-checking bench for wb_stage_mlane against a queue-based retirement model.
module tb_wb_stage_mlane;
  localparam int LANES  = 2;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
  localparam int LW     = 1 + ADDR_W + DATA_W;
`ifdef WB_TRACE_EN
  localparam bit TRACE = 1'b1;
`else
  localparam bit TRACE = 1'b0;
`endif

  logic                          clk = 1'b0;
  logic                          rst, flush, in_valid, in_ready;
  logic [LANES-1:0]              in_lane_vld, in_rf_we;
  logic [LANES*32-1:0]           in_pc;
  logic [LANES*ADDR_W-1:0]       in_rf_waddr;
  logic [LANES*DATA_W-1:0]       in_rf_wdata;
  logic [1:0]                    in_hilo_we;
  logic [DATA_W-1:0]             in_hi, in_lo;
  logic [LANES-1:0]              rf_we;
  logic [LANES*ADDR_W-1:0]       rf_waddr;
  logic [LANES*DATA_W-1:0]       rf_wdata;
  logic [LANES*LW-1:0]           fwd_rf_bus;
  logic [1:0]                    hilo_we;
  logic [DATA_W-1:0]             hi_o, lo_o;
  logic [2+2*DATA_W-1:0]         fwd_hilo_bus;
  logic [63:0]                   instret;
  logic [31:0]                   debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]                    debug_wb_rf_wen;
  logic [4:0]                    debug_wb_rf_wnum;
  logic                          trace_busy;

  wb_stage_mlane #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TRACE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_vld(in_lane_vld), .in_pc(in_pc), .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr),
    .in_rf_wdata(in_rf_wdata), .in_hilo_we(in_hilo_we), .in_hi(in_hi), .in_lo(in_lo),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .fwd_rf_bus(fwd_rf_bus),
    .hilo_we(hilo_we), .hi_o(hi_o), .lo_o(lo_o), .fwd_hilo_bus(fwd_hilo_bus),
    .instret(instret), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .trace_busy(trace_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } tent_t;

  tent_t       tq[$];
  logic [63:0] m_instret;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_lane_vld = '0; in_rf_we = '0; in_pc = '0; in_rf_waddr = '0; in_rf_wdata = '0;
    in_hilo_we = '0; in_hi = '0; in_lo = '0;
  endtask

  task automatic set_lane(input int i, input logic vld, input logic we, input logic [4:0] wa,
                          input logic [31:0] wd, input logic [31:0] pc);
    in_lane_vld[i] = vld;
    in_rf_we[i] = we;
    in_rf_waddr[i*ADDR_W +: ADDR_W] = wa;
    in_rf_wdata[i*DATA_W +: DATA_W] = wd;
    in_pc[i*32 +: 32] = pc;
  endtask

  // One clock: predict from current inputs and model state, advance, then compare.
  task automatic step();
    logic [LANES-1:0]        e_we;
    logic [LANES*ADDR_W-1:0] e_wa;
    logic [LANES*DATA_W-1:0] e_wd;
    logic [LANES*LW-1:0]     e_fwd;
    logic [1:0]              e_hw;
    logic [31:0]             e_hi, e_lo;
    logic [4:0]              wa;
    tent_t                   d;
    bit                      d_valid, rdy, acc;
    int                      owner[int];
    e_we = '0; e_wa = '0; e_wd = '0; e_hw = '0; e_hi = '0; e_lo = '0; e_fwd = '0;
    d = '{pc: '0, we: 1'b0, wnum: '0, wdata: '0};
    d_valid = 1'b0;
    rdy = TRACE ? ((DEPTH - tq.size()) >= LANES) : 1'b1;
    chk("in_ready", in_ready, rdy);
    acc = in_valid && rdy && !flush;
    if (rst) begin
      tq.delete();
      m_instret = '0;
    end else begin
      if (tq.size() > 0) begin
        d = tq.pop_front();
        d_valid = 1'b1;
      end
      if (acc) begin
        for (int i = 0; i < LANES; i++) begin
          wa = in_rf_waddr[i*ADDR_W +: ADDR_W];
          if (in_lane_vld[i]) begin
            m_instret++;
            if (TRACE) tq.push_back('{in_pc[i*32 +: 32], in_rf_we[i], wa, in_rf_wdata[i*DATA_W +: DATA_W]});
            if (in_rf_we[i] && wa != 0) owner[int'(wa)] = i;
          end
        end
        for (int i = 0; i < LANES; i++) begin
          wa = in_rf_waddr[i*ADDR_W +: ADDR_W];
          e_we[i] = in_lane_vld[i] && in_rf_we[i] && wa != 0 && owner.exists(int'(wa)) && owner[int'(wa)] == i;
        end
        e_wa = in_rf_waddr; e_wd = in_rf_wdata;
        e_hw = in_hilo_we; e_hi = in_hi; e_lo = in_lo;
      end
    end
    for (int i = 0; i < LANES; i++)
      e_fwd[i*LW +: LW] = {e_we[i], e_wa[i*ADDR_W +: ADDR_W], e_wd[i*DATA_W +: DATA_W]};
    @(posedge clk); #1;
    chk("rf_we", rf_we, e_we);
    chk("rf_waddr", rf_waddr, e_wa);
    chk("rf_wdata", rf_wdata, e_wd);
    chk("fwd_rf_bus", fwd_rf_bus, e_fwd);
    chk("hilo_we", hilo_we, e_hw);
    chk("hi_o", hi_o, e_hi);
    chk("lo_o", lo_o, e_lo);
    chk("fwd_hilo_bus", fwd_hilo_bus, {e_hw, e_hi, e_lo});
    chk("instret", instret, m_instret);
    chk("trace_busy", trace_busy, tq.size() > 0);
    chk("dbg_pc", debug_wb_pc, d_valid ? d.pc : 32'h0);
    chk("dbg_wen", debug_wb_rf_wen, (d_valid && d.we) ? 4'hF : 4'h0);
    chk("dbg_wnum", debug_wb_rf_wnum, d_valid ? d.wnum : 5'h0);
    chk("dbg_wdata", debug_wb_rf_wdata, d_valid ? d.wdata : 32'h0);
  endtask

  task automatic drain();
    clear_in();
    repeat (6) step();
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    m_instret = '0;
    @(posedge clk); #1;
    step();
    chk("rst_instret", instret, 64'h0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_busy", trace_busy, 1'b0);
    chk("rst_dbg_pc", debug_wb_pc, 32'h0);

    // Single lane-0 retirement
    clear_in(); in_valid = 1'b1;
    set_lane(0, 1'b1, 1'b1, 5'd3, 32'h11, 32'hBFC0_0000);
    step();
    chk("t1_rf_we", rf_we, 2'b01);
    chk("t1_instret", instret, 64'd1);
    clear_in();
    step();
    chk("t1_bubble", rf_we, 2'b00);
    drain();

    // Same-address conflict
    clear_in(); in_valid = 1'b1;
    set_lane(0, 1'b1, 1'b1, 5'd8, 32'hA, 32'h100);
    set_lane(1, 1'b1, 1'b1, 5'd8, 32'hB, 32'h104);
    step();
    chk("t2_rf_we", rf_we, 2'b10);
    chk("t2_wdata1", rf_wdata[63:32], 32'hB);
    drain();

    // Write to $zero
    clear_in(); in_valid = 1'b1;
    set_lane(0, 1'b1, 1'b1, 5'd0, 32'h55, 32'h200);
    step();
    chk("t3_rf_we", rf_we, 2'b00);
    drain();

    // Back-to-back full bundles
    clear_in(); in_valid = 1'b1;
    set_lane(0, 1'b1, 1'b1, 5'd1, 32'h1, 32'h300);
    set_lane(1, 1'b1, 1'b1, 5'd2, 32'h2, 32'h304);
    step();
    set_lane(0, 1'b1, 1'b1, 5'd4, 32'h3, 32'h308);
    set_lane(1, 1'b1, 1'b0, 5'd5, 32'h4, 32'h30C);
    step();
    chk("t4_ready", in_ready, !TRACE);
    step();
    drain();

    // Flushed bundle with HI/LO write
    clear_in(); in_valid = 1'b1; flush = 1'b1; in_hilo_we = 2'b11;
    in_hi = 32'hDEAD; in_lo = 32'hBEEF;
    set_lane(0, 1'b1, 1'b1, 5'd6, 32'h6, 32'h400);
    set_lane(1, 1'b1, 1'b1, 5'd7, 32'h7, 32'h404);
    step();
    chk("t5_hilo", hilo_we, 2'b00);
    chk("t5_busy", trace_busy, 1'b0);
    clear_in();
    step();
    chk("t5_bubble", rf_we, 2'b00);
    drain();

    // Reset while entries are queued
    clear_in(); in_valid = 1'b1;
    set_lane(0, 1'b1, 1'b1, 5'd9, 32'h9, 32'h500);
    set_lane(1, 1'b1, 1'b1, 5'd10, 32'h10, 32'h504);
    step();
    step();
    chk("t6_busy_pre", trace_busy, TRACE);
    clear_in(); rst = 1'b1;
    step();
    chk("t6_busy", trace_busy, 1'b0);
    chk("t6_instret", instret, 64'h0);
    chk("t6_ready", in_ready, 1'b1);
    chk("t6_dbg_wen", debug_wb_rf_wen, 4'h0);
    chk("t6_dbg_pc", debug_wb_pc, 32'h0);

    for (int c = 0; c < 400; c++) begin
      clear_in();
      in_valid = ($urandom_range(3) != 0);
      flush = ($urandom_range(9) == 0);
      rst = ($urandom_range(99) == 0);
      for (int i = 0; i < LANES; i++)
        set_lane(i, 1'($urandom_range(1)), 1'($urandom_range(1)), 5'($urandom_range(3)),
                 $urandom, $urandom);
      in_hilo_we = 2'($urandom_range(3));
      in_hi = $urandom;
      in_lo = $urandom;
      step();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
